// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state encoding, default width and sizing helper for mont_mul
package mont_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Bits needed to count 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mont_step.sv
// rtl/mont_step.sv - one combinational Montgomery iteration: t_o = (t + a_bit*b + q*m) / 2
module mont_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] t_i,
  input  logic             a_bit_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH+1:0] t_o
);

  logic [WIDTH+1:0] t1;
  logic [WIDTH+1:0] t2;

  // With t < 2m and b < m, t2 < 4m, so WIDTH+2 bits never overflow.
  assign t1  = t_i + (a_bit_i ? {2'b00, b_i} : '0);
  assign t2  = t1 + (t1[0] ? {2'b00, m_i} : '0);
  assign t_o = {1'b0, t2[WIDTH+1:1]};

endmodule

// File: rtl/mont_mul.sv
// rtl/mont_mul.sv - bit-serial Montgomery multiplier, result = a*b*2^-WIDTH mod m
// Optional operand checking when MONT_ERR_CHECK_EN is defined.
module mont_mul
  import mont_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = clog2(WIDTH);
  localparam int TW = WIDTH + 2;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [TW-1:0]    t_q;
  logic [TW-1:0]    t_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] corr_d;
  logic [TW-1:0]    m_ext;
  logic             busy_q;
  logic             done_q;
  logic             last_iter;

  mont_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .t_i    (t_q),
    .a_bit_i(a_q[cnt_q]),
    .b_i    (b_q),
    .m_i    (m_q),
    .t_o    (t_d)
  );

  assign m_ext     = {2'b00, m_q};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  // Accumulator ends below 2m, so a single conditional subtract fully reduces it.
  assign corr_d    = (t_q >= m_ext) ? WIDTH'(t_q - m_ext) : t_q[WIDTH-1:0];

`ifdef MONT_ERR_CHECK_EN
  logic err_q;
  logic operand_bad;

  assign operand_bad = !m[0] || (m <= WIDTH'(1)) || (a >= m) || (b >= m);
  assign err         = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
`ifdef MONT_ERR_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MONT_ERR_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        // ERR is the done cycle of a rejected job and accepts a new start like IDLE.
        IDLE, ERR: begin
          state_q <= IDLE;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            t_q   <= '0;
            cnt_q <= '0;
`ifdef MONT_ERR_CHECK_EN
            if (operand_bad) begin
              state_q  <= ERR;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
            end else
`endif
            begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          t_q   <= t_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) state_q <= CORR;
        end
        CORR: begin
          result_q <= corr_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mont_mul.sv
// tb/tb_mont_mul.sv - self-checking bench for mont_mul (vector table, corner sequences, random jobs)
module tb_mont_mul;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] m;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;

  int n_cmp;
  int n_fail;
  int cyc;
  int start_cyc;

  mont_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .result(result),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the unique x < m with x * 2^W == a*b (mod m).
  function automatic int ref_mont(input int av, input int bv, input int mv);
    int p;
    p = (av * bv) % mv;
    for (int x = 0; x < mv; x++) begin
      if (((x * (1 << W)) % mv) == p) return x;
    end
    return -1;
  endfunction

  task automatic issue(input int av, input int bv, input int mv);
    a = W'(av);
    b = W'(bv);
    m = W'(mv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic launch(input int av, input int bv, input int mv);
    @(negedge clk);
    issue(av, bv, mv);
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    bcnt = 0;
    while (!done && (cyc - start_cyc) < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
    end
    lat = cyc - start_cyc;
  endtask

  task automatic run_job(input string name, input int av, input int bv, input int mv,
                         input int exp_res);
    int lat;
    int bcnt;
    launch(av, bv, mv);
    wait_done(lat, bcnt);
    check({name, " latency"}, lat, W + 1);
    check({name, " result"}, int'(result), exp_res);
    check({name, " err"}, int'(err), 0);
    check({name, " busy in done cycle"}, int'(busy), 0);
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, int'(done), 0);
  endtask

  initial begin
    int lat;
    int bcnt;
    int rm;
    int ra;
    int rb;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    m      = '0;

    vecs[0] = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  exp: 8'd1};
    vecs[1] = '{a: 8'd1,   b: 8'd1,   m: 8'd13,  exp: 8'd3};
    vecs[2] = '{a: 8'd0,   b: 8'd12,  m: 8'd13,  exp: 8'd0};
    vecs[3] = '{a: 8'd254, b: 8'd254, m: 8'd255, exp: 8'd1};
    vecs[4] = '{a: 8'd12,  b: 8'd12,  m: 8'd13,  exp: 8'd3};
    vecs[5] = '{a: 8'd2,   b: 8'd3,   m: 8'd255, exp: 8'd6};
    vecs[6] = '{a: 8'd2,   b: 8'd2,   m: 8'd3,   exp: 8'd1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    check("reset result", int'(result), 0);
    rst = 1'b0;

    // Main timing case: busy must be high for exactly W+1 cycles.
    launch(5, 7, 13);
    wait_done(lat, bcnt);
    check("basic latency", lat, W + 1);
    check("basic busy cycles", bcnt, W + 1);
    check("basic result", int'(result), 1);
    check("basic err", int'(err), 0);

    for (int i = 0; i < 7; i++) begin
      run_job($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].m),
              int'(vecs[i].exp));
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    launch(5, 7, 13);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a = 8'd1;
    b = 8'd1;
    m = 8'd13;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'd9;
    b = 8'd9;
    m = 8'd9;
    start_cyc = start_cyc;
    wait_done(lat, bcnt);
    check("ignored start latency", lat, W + 1);
    check("ignored start result", int'(result), 1);
    issue(1, 1, 13);
    wait_done(lat, bcnt);
    check("done-cycle start latency", lat, W + 1);
    check("done-cycle start result", int'(result), 3);

    // Reset in cycle 4 of a job aborts it without a done.
    launch(5, 7, 13);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort result", int'(result), 0);
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        if (done) seen++;
        @(posedge clk);
        #1;
      end
      check("abort no done", seen, 0);
    end
    run_job("after abort", 254, 254, 255, 1);

`ifdef MONT_ERR_CHECK_EN
    launch(5, 7, 12);
    wait_done(lat, bcnt);
    check("err even m latency", lat, 0);
    check("err even m flag", int'(err), 1);
    check("err even m result", int'(result), 0);
    launch(13, 1, 13);
    wait_done(lat, bcnt);
    check("err a>=m latency", lat, 0);
    check("err a>=m flag", int'(err), 1);
    check("err a>=m result", int'(result), 0);
    run_job("valid after err", 5, 7, 13, 1);
`else
    launch(5, 7, 12);
    wait_done(lat, bcnt);
    check("invalid m latency", lat, W + 1);
    check("invalid m err", int'(err), 0);
`endif

    for (int i = 0; i < 30; i++) begin
      rm = 2 * int'($urandom_range(1, 127)) + 1;
      ra = int'($urandom_range(0, rm - 1));
      rb = int'($urandom_range(0, rm - 1));
      run_job($sformatf("rand%0d a=%0d b=%0d m=%0d", i, ra, rb, rm), ra, rb, rm,
              ref_mont(ra, rb, rm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
